sensor_bin_scheduler: RTL

Sequences the three sensor bins onto the board's single shared status/display path. It debounces the three-button `CHOICE_button` input and selects one bin manually or rotates through all three automatically. It runs a valid/ack capture handshake with the selected bin only, and drives `STATUS_led` plus the two-digit seven-segment display from the captured reading. It sits between the sensor-reading block and the board pins, clocked by `Clk` and paced by the slow-rate enable from the clock divider.

---
 rtl/sensor_bin_scheduler_pkg.sv | 40 ++++
 rtl/button_debounce.sv | 53 +++++
 rtl/sensor_bin_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sensor_bin_scheduler_pkg.sv
// Shared types and seven-segment constants for the sensor bin scheduler.
package sensor_bin_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MANUAL,
    S_AUTO
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Tick-paced stable-count filter for the 3-button input.
// changed is combinational so the action lands on the accepting tick edge.
module button_debounce #(
  parameter int TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] raw,
  output logic [2:0] pattern,
  output logic       changed
);

  localparam int CW = $clog2(TICKS + 1);

  logic [2:0]    samp_q, samp_d;
  logic [2:0]    acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    samp_d  = samp_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    changed = 1'b0;
    if (tick) begin
      samp_d = raw;
      if (raw != samp_q) begin
        cnt_d = CW'(1);
      end else if (cnt_q != CW'(TICKS)) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (cnt_d == CW'(TICKS) && raw != acc_q) begin
        acc_d   = raw;
        changed = 1'b1;
      end
    end
  end

  assign pattern = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else begin
      samp_q <= samp_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/sensor_bin_scheduler.sv
// Selects one of three sensor bins, captures its reading via valid/ack,
// and drives the status LEDs and two-digit seven-segment display.
module sensor_bin_scheduler
  import sensor_bin_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int DWELL_TICKS    = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        tick,
  input  logic [2:0]  CHOICE_button,
  input  logic [23:0] status_bus,
  input  logic [11:0] value_bus,
  input  logic [2:0]  bin_valid,
  output logic [2:0]  bin_ack,
  output logic [1:0]  active_bin,
  output logic [7:0]  STATUS_led,
  output logic [7:0]  STATUS_7seg_ones,
  output logic [7:0]  STATUS_7seg_tens
);

  localparam int DW = $clog2(DWELL_TICKS + 1);

  logic [2:0] btn_pat;
  logic       btn_chg;

  button_debounce #(.TICKS(DEBOUNCE_TICKS)) u_db (
    .clk     (Clk),
    .rst     (Rst),
    .tick    (tick),
    .raw     (CHOICE_button),
    .pattern (btn_pat),
    .changed (btn_chg)
  );

  state_t        state_q, state_d;
  logic [1:0]    active_q, active_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [2:0]    ack_q, ack_d;
  logic          live_q, live_d;
  logic [1:0]    abin_q, abin_d;
  logic          lvld_q, lvld_d;
  logic [7:0]    lst_q, lst_d;
  logic [3:0]    lval_q, lval_d;
  logic [7:0]    led_q, led_d;
  logic [7:0]    ones_q, ones_d;
  logic [7:0]    tens_q, tens_d;
  logic          sel_chg;
  logic          capture;
  logic [3:0]    ones_dig;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    dwell_d  = dwell_q;
    sel_chg  = 1'b0;
    if (btn_chg && btn_pat != 3'b000) begin
      sel_chg = 1'b1;
      dwell_d = '0;
      if (btn_pat == 3'b111) begin
        state_d  = S_AUTO;
        active_d = 2'd0;
      end else begin
        state_d  = S_MANUAL;
        active_d = btn_pat[0] ? 2'd0 : (btn_pat[1] ? 2'd1 : 2'd2);
      end
    end else if (state_q == S_AUTO && tick) begin
      if (dwell_q == DW'(DWELL_TICKS - 1)) begin
        sel_chg  = 1'b1;
        dwell_d  = '0;
        active_d = (active_q == 2'd2) ? 2'd0 : active_q + 2'd1;
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end
  end

  // Capture uses the pre-change bin; a same-edge bin change kills the load.
  always_comb begin
    capture = (state_q != S_IDLE) && bin_valid[active_q] && !ack_q[active_q];
    ack_d   = capture ? (3'b001 << active_q) : 3'b000;
    live_d  = capture && !sel_chg;
    abin_d  = active_q;
    lvld_d  = lvld_q;
    lst_d   = lst_q;
    lval_d  = lval_q;
    if (sel_chg) begin
      lvld_d = 1'b0;
      lst_d  = 8'h00;
      lval_d = 4'd0;
    end else if (live_q) begin
      lvld_d = 1'b1;
      lst_d  = status_bus[{abin_q, 3'b000} +: 8];
      lval_d = value_bus[{abin_q, 2'b00} +: 4];
    end
  end

  always_comb begin
    ones_dig = (lval_q >= 4'd10) ? lval_q - 4'd10 : lval_q;
    led_d    = lst_q;
    ones_d   = lvld_q ? seg7(ones_dig) : SEG_BLANK;
    tens_d   = (lvld_q && lval_q >= 4'd10) ? SEG_1 : SEG_BLANK;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      active_q <= 2'd0;
      dwell_q  <= '0;
      ack_q    <= 3'b000;
      live_q   <= 1'b0;
      abin_q   <= 2'd0;
      lvld_q   <= 1'b0;
      lst_q    <= 8'h00;
      lval_q   <= 4'd0;
      led_q    <= 8'h00;
      ones_q   <= SEG_BLANK;
      tens_q   <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      dwell_q  <= dwell_d;
      ack_q    <= ack_d;
      live_q   <= live_d;
      abin_q   <= abin_d;
      lvld_q   <= lvld_d;
      lst_q    <= lst_d;
      lval_q   <= lval_d;
      led_q    <= led_d;
      ones_q   <= ones_d;
      tens_q   <= tens_d;
    end
  end

  assign bin_ack          = ack_q;
  assign active_bin       = active_q;
  assign STATUS_led       = led_q;
  assign STATUS_7seg_ones = ones_q;
  assign STATUS_7seg_tens = tens_q;

endmodule
